// File: rtl/pll_reconfig_pkg.sv
// Shared types, register map and per-profile settings for the PLL reconfiguration sequencer.
// Every profile uses a 50 MHz reference and a single VCO that feeds C0-C3.
package pll_reconfig_pkg;

    localparam int PROFILE_ROWS = 4;
    localparam int NUM_LOAD     = 9;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;
    localparam logic [5:0] ADDR_BW    = 6'h08;
    localparam logic [5:0] ADDR_CP    = 6'h09;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } reconfig_entry_t;

    typedef reconfig_entry_t [0:NUM_LOAD-1] profile_row_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_LOAD,
        ST_START,
        ST_HOLDOFF,
        ST_WAIT_LOCK
    } state_t;

    // Counter word: [22:18] counter select, [17] odd divide, [16] bypass, [15:8] high, [7:0] low.
    function automatic logic [31:0] div_word(input int unsigned div, input int unsigned sel);
        logic [31:0] w;
        w = '0;
        if (div <= 1) begin
            w[16] = 1'b1;
        end else begin
            w[7:0]  = 8'(div / 2);
            w[15:8] = 8'(div - div / 2);
            w[17]   = 1'(div % 2);
        end
        w[22:18] = 5'(sel);
        return w;
    endfunction

    function automatic profile_row_t make_row(
        input int unsigned m,
        input logic [31:0] k,
        input int unsigned c0,
        input int unsigned c1,
        input int unsigned c2,
        input int unsigned c3,
        input logic [3:0]  bw,
        input logic [2:0]  cp
    );
        profile_row_t row;
        row[0] = '{addr: ADDR_N,  data: div_word(1, 0)};
        row[1] = '{addr: ADDR_M,  data: div_word(m, 0)};
        row[2] = '{addr: ADDR_C,  data: div_word(c0, 0)};
        row[3] = '{addr: ADDR_C,  data: div_word(c1, 1)};
        row[4] = '{addr: ADDR_C,  data: div_word(c2, 2)};
        row[5] = '{addr: ADDR_C,  data: div_word(c3, 3)};
        row[6] = '{addr: ADDR_K,  data: k};
        row[7] = '{addr: ADDR_BW, data: {28'd0, bw}};
        row[8] = '{addr: ADDR_CP, data: {29'd0, cp}};
        return row;
    endfunction

    // VCO 567.5 (M=11.35) / 600 / 500 / 700 MHz; profile 0 gives 47.29/63.06/31.53/141.88 MHz.
    localparam profile_row_t PROFILE_TABLE [PROFILE_ROWS] = '{
        make_row(11, 32'h5999_999A, 12,  9, 18, 4, 4'd6, 3'd2),
        make_row(12, 32'h0000_0000, 12,  8, 24, 6, 4'd6, 3'd2),
        make_row(10, 32'h0000_0000,  5, 10, 20, 4, 4'd7, 3'd3),
        make_row(14, 32'h0000_0000,  7, 14, 28, 5, 4'd7, 3'd3)
    };

endpackage

// File: rtl/pll_reconfig_seq_sync2.sv
// Two-flop synchroniser for pll_locked; clr flushes it so stale lock is never seen.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        ff_d = clr ? 2'b00 : {ff_q[0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/pll_reconfig_seq.sv
// Walks the PLL reconfig IP through mode, profile load and start writes, then waits for re-lock.
// rst_n is shared with the reconfig IP, so after reset both sides agree the PLL is in profile 0.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_PROFILES = PROFILE_ROWS,
    parameter int LOCK_HOLDOFF = 16,
    parameter int LOCK_TIMEOUT = 1_048_576
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req,
    input  logic [$clog2(NUM_PROFILES)-1:0] req_profile,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [$clog2(NUM_PROFILES)-1:0] cur_profile,
    output logic [5:0]                      mgmt_address,
    output logic                            mgmt_write,
    output logic [31:0]                     mgmt_writedata,
    input  logic                            mgmt_waitrequest,
    input  logic                            pll_locked
);

    localparam int PW    = $clog2(NUM_PROFILES);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT > LOCK_HOLDOFF ? LOCK_TIMEOUT : LOCK_HOLDOFF) + 1;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic [5:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic [PW-1:0]     tgt_q, tgt_d;
    logic [3:0]        entry_q, entry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     req_idx;
    logic              accepted;
    logic              lock_sync;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_WAIT_LOCK),
        .d     (pll_locked),
        .q     (lock_sync)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        accepted = write_q && !mgmt_waitrequest;
        req_idx  = (int'(req_profile) >= NUM_PROFILES) ? PW'(NUM_PROFILES - 1) : req_profile;

        // Each write is followed by one idle bus cycle before the next one is presented.
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_idx == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = req_idx;
                        busy_d  = 1'b1;
                        write_d = 1'b1;
                        addr_d  = ADDR_MODE;
                        wdata_d = '0;
                        state_d = ST_MODE;
                    end
                end
            end
            ST_MODE: begin
                if (accepted) begin
                    write_d = 1'b0;
                    entry_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accepted) begin
                    write_d = 1'b0;
                    if (entry_q == 4'(NUM_LOAD - 1)) begin
                        state_d = ST_START;
                    end else begin
                        entry_d = entry_q + 4'd1;
                    end
                end else if (!write_q) begin
                    write_d = 1'b1;
                    addr_d  = PROFILE_TABLE[tgt_q][entry_q].addr;
                    wdata_d = PROFILE_TABLE[tgt_q][entry_q].data;
                end
            end
            ST_START: begin
                if (accepted) begin
                    write_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_HOLDOFF;
                end else if (!write_q) begin
                    write_d = 1'b1;
                    addr_d  = ADDR_START;
                    wdata_d = 32'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == CNT_W'(LOCK_HOLDOFF - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    cur_d   = tgt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_profile    = cur_q;
    assign mgmt_address   = addr_q;
    assign mgmt_write     = write_q;
    assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq with a register-map model, bus-rule monitor and lock/stall stimulus.
module tb_pll_reconfig_seq;

    localparam int NP = 4;
    localparam int H  = 16;
    localparam int T  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  req_profile;
    logic        busy, done, err;
    logic [1:0]  cur_profile;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    pll_reconfig_seq #(
        .NUM_PROFILES (NP),
        .LOCK_HOLDOFF (H),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_profile      (req_profile),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .cur_profile      (cur_profile),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Profile settings as PLL divider values, independent of the RTL table encoding.
    int          b_m  [NP]     = '{11, 12, 10, 14};
    int          b_c  [NP][4]  = '{'{12, 9, 18, 4}, '{12, 8, 24, 6}, '{5, 10, 20, 4}, '{7, 14, 28, 5}};
    logic [31:0] b_k  [NP]     = '{32'h5999_999A, 32'h0, 32'h0, 32'h0};
    int          b_bw [NP]     = '{6, 6, 7, 7};
    int          b_cp [NP]     = '{2, 2, 3, 3};

    function automatic logic [31:0] enc(input int div, input int sel);
        if (div == 1) return 32'(65536 + sel * 262144);
        return 32'(sel * 262144 + (div % 2) * 131072 + ((div + 1) / 2) * 256 + div / 2);
    endfunction

    logic [37:0] exp_q [$];
    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];

    function automatic void push_profile(input int p);
        exp_q.push_back({6'h00, 32'd0});
        exp_q.push_back({6'h03, enc(1, 0)});
        exp_q.push_back({6'h04, enc(b_m[p], 0)});
        for (int i = 0; i < 4; i++) exp_q.push_back({6'h05, enc(b_c[p][i], i)});
        exp_q.push_back({6'h07, b_k[p]});
        exp_q.push_back({6'h08, 32'(b_bw[p])});
        exp_q.push_back({6'h09, 32'(b_cp[p])});
        exp_q.push_back({6'h02, 32'd1});
    endfunction

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_busy = 1'b0;
    logic        m_same = 1'b0;
    int          m_cur = 0;
    int          m_tgt = 0;
    int          m_start = -1;
    int          n_done = 0;
    int          n_err = 0;
    logic        rst_pend = 1'b0;
    logic        lock_low = 1'b0;
    logic        stalled = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic [5:0]  stall_addr = 6'h3F;

    // Reconfig IP stall model: waitrequest only on the chosen address, for stall_left cycles.
    always @(posedge clk) begin
        #1;
        if (mgmt_write && mgmt_address == stall_addr && stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
    end

    always @(negedge clk) begin
        int          p;
        int          delta;
        logic [37:0] e;
        if (rst_pend) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_write", mgmt_write, 0);
            check("rst_addr", mgmt_address, 0);
            check("rst_data", mgmt_writedata, 0);
            check("rst_cur", cur_profile, 0);
            m_busy = 1'b0; m_same = 1'b0; m_cur = 0; m_start = -1;
            stalled = 1'b0;
            exp_q.delete();
            rst_pend = 1'b0;
        end else begin
            delta = cyc - m_start;
            if (m_same) begin
                check("same_done", done, 1);
                m_same = 1'b0;
            end else if (done) begin
                check("done_window", (m_busy && m_start >= 0 && !lock_low && delta >= H + 1 && delta <= H + 5), 1);
                check("done_writes_left", exp_q.size(), 0);
                m_busy = 1'b0; m_cur = m_tgt; n_done++;
            end else if (err) begin
                check("err_window", (m_busy && m_start >= 0 && lock_low && delta >= H + T && delta <= H + T + 3), 1);
                m_busy = 1'b0; n_err++;
            end
            check("done_err_excl", done && err, 0);
            check("busy", busy, m_busy);
            check("cur_profile", cur_profile, m_cur);
            if (stalled) begin
                check("stall_write_held", mgmt_write, 1);
                check("stall_addr_held", mgmt_address, prev_addr);
                check("stall_data_held", mgmt_writedata, prev_data);
            end
            if (mgmt_write) begin
                check("write_only_when_busy", m_busy, 1);
                if (!mgmt_waitrequest) begin
                    check("write_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", mgmt_address, e[37:32]);
                        check("wr_data", mgmt_writedata, e[31:0]);
                    end
                    log_addr.push_back(mgmt_address);
                    log_data.push_back(mgmt_writedata);
                    if (mgmt_address == 6'h02) m_start = cyc;
                end
            end
            stalled   = mgmt_write && mgmt_waitrequest;
            prev_addr = mgmt_address;
            prev_data = mgmt_writedata;
            if (rst_n && req && !m_busy) begin
                p = (int'(req_profile) > NP - 1) ? NP - 1 : int'(req_profile);
                if (p == m_cur) begin
                    m_same = 1'b1;
                end else begin
                    m_busy = 1'b1; m_tgt = p; m_start = -1;
                    push_profile(p);
                end
            end
        end
        if (!rst_n) rst_pend = 1'b1;
        // PLL model: lock drops once a switch begins and returns 10 cycles after start.
        pll_locked = lock_low ? 1'b0 : !(m_busy && (m_start < 0 || cyc < m_start + 10));
    end

    task automatic send_req(input logic [1:0] p);
        @(posedge clk); #1;
        req = 1'b1; req_profile = p;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((m_busy || m_same) && n < budget);
        check(name, (m_busy || m_same) ? 0 : 1, 1);
    endtask

    function automatic int count_addr(input logic [5:0] a);
        int c = 0;
        foreach (log_addr[i]) if (log_addr[i] == a) c++;
        return c;
    endfunction

    initial begin
        int d0, e0;
        int found;
        rst_n = 1'b0; req = 1'b0; req_profile = '0;
        mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk); #1;
        check("init_busy", busy, 0);
        check("init_write", mgmt_write, 0);
        check("init_cur", cur_profile, 0);

        // Same profile: done next cycle, no bus traffic.
        log_addr.delete(); log_data.delete();
        send_req(2'd0);
        @(negedge clk); #1;
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t1_no_writes", log_addr.size(), 0);

        // Full switch to profile 2.
        d0 = n_done;
        log_addr.delete(); log_data.delete();
        send_req(2'd2);
        wait_idle("t2_idle", 200);
        check("t2_done_count", n_done - d0, 1);
        check("t2_cur", cur_profile, 2);
        check("t2_nwrites", log_addr.size(), 11);
        if (log_addr.size() == 11) begin
            check("t2_n_word", log_data[1], 32'h0001_0000);
            check("t2_m_word", log_data[2], 32'h0000_0505);
            check("t2_c0_word", log_data[3], 32'h0002_0302);
            check("t2_c2_word", log_data[5], 32'h0008_0A0A);
            check("t2_cp_word", log_data[9], 32'h0000_0003);
            check("t2_last_addr", log_addr[10], 6'h02);
        end

        // Five waitrequest cycles on the M write.
        d0 = n_done;
        log_addr.delete(); log_data.delete();
        stall_addr = 6'h04; stall_left = 5; stall_seen = 0;
        send_req(2'd1);
        wait_idle("t3_idle", 200);
        check("t3_stall_cycles", stall_seen, 5);
        check("t3_m_once", count_addr(6'h04), 1);
        check("t3_nwrites", log_addr.size(), 11);
        check("t3_cur", cur_profile, 1);
        check("t3_done_count", n_done - d0, 1);
        stall_addr = 6'h3F;

        // Request during LOAD is dropped.
        d0 = n_done;
        log_addr.delete(); log_data.delete();
        send_req(2'd3);
        repeat (6) @(posedge clk);
        send_req(2'd0);
        wait_idle("t4_idle", 200);
        check("t4_cur", cur_profile, 3);
        check("t4_nwrites", log_addr.size(), 11);
        if (log_addr.size() == 11) check("t4_m_word", log_data[2], 32'h0000_0707);
        repeat (4) @(negedge clk);
        check("t4_done_count", n_done - d0, 1);

        // Lock never returns: err, profile unchanged, then a retry succeeds.
        e0 = n_err;
        lock_low = 1'b1;
        send_req(2'd2);
        wait_idle("t5_idle", 300);
        check("t5_err_count", n_err - e0, 1);
        check("t5_cur", cur_profile, 3);
        lock_low = 1'b0;
        d0 = n_done;
        send_req(2'd2);
        wait_idle("t5_retry_idle", 200);
        check("t5_retry_done", n_done - d0, 1);
        check("t5_retry_cur", cur_profile, 2);

        // Reset while the K write is on the bus.
        send_req(2'd0);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(posedge clk); #1;
            if (mgmt_write && mgmt_address == 6'h07) found = 1;
        end
        check("t6_k_seen", found, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_write", mgmt_write, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cur", cur_profile, 0);
        d0 = n_done;
        send_req(2'd1);
        wait_idle("t6_idle", 200);
        check("t6_done_count", n_done - d0, 1);
        check("t6_cur", cur_profile, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
